// File: rtl/axil_crossbar_m_arb.sv
// ---------------------------------------------------------------------------
// axil_crossbar_m_arb
//
// Admission arbiter for one AXI-lite crossbar master port (write or read
// path). Several slave-side decoders request the port; one is granted at a
// time, and the number of outstanding transactions is capped at M_ISSUE.
// Every accepted grant pushes its source index into an ordering FIFO so the
// returning B/R responses can be steered back in issue order.
//
// Optional feature macro:
//   AXIL_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration starting
//                                         after the last granted source
//                            undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   s_req             per-source request, held until accepted
//   s_grant           one-hot registered grant
//   grant_valid       a grant is active
//   grant_encoded     binary index of the granted source
//   m_aready          master port accepted the granted address this cycle
//   m_resp_done       one response completed its handshake this cycle
//   resp_select       source index of the response at the FIFO head
//   resp_select_valid ordering FIFO non-empty
//   outstanding       current outstanding transaction count
//   full              outstanding == M_ISSUE
// ---------------------------------------------------------------------------
module axil_crossbar_m_arb #(
    parameter int S_COUNT    = 4,
    parameter int M_ISSUE    = 4,
    parameter int CL_S_COUNT = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
    parameter int CL_ISSUE   = $clog2(M_ISSUE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [S_COUNT-1:0]    s_req,
    output logic [S_COUNT-1:0]    s_grant,
    output logic                  grant_valid,
    output logic [CL_S_COUNT-1:0] grant_encoded,
    input  logic                  m_aready,
    input  logic                  m_resp_done,
    output logic [CL_S_COUNT-1:0] resp_select,
    output logic                  resp_select_valid,
    output logic [CL_ISSUE-1:0]   outstanding,
    output logic                  full
);

    // FIFO index width; a wrap bit on top distinguishes full from empty
    localparam int IDX_W = (M_ISSUE > 1) ? $clog2(M_ISSUE) : 1;
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_r;
    logic [S_COUNT-1:0]      s_grant_r;
    logic                    grant_valid_r;
    logic [CL_S_COUNT-1:0]   grant_encoded_r;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic [CL_S_COUNT-1:0]   last_r;
`endif

    logic [CL_S_COUNT-1:0]   winner_s;
    logic [S_COUNT-1:0]      winner_onehot_s;
    logic                    any_req_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    admit_s;

    logic [CL_S_COUNT-1:0]   mem_r [M_ISSUE];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        next_wr_s;
    logic [PTR_W-1:0]        next_rd_s;
    logic                    next_empty_s;
    logic [CL_S_COUNT-1:0]   head_r;
    logic [CL_S_COUNT-1:0]   next_head_s;
    logic                    head_valid_r;
    logic [CL_ISSUE-1:0]     outstanding_r;
    logic [CL_ISSUE-1:0]     next_out_s;
    logic                    full_r;

    // Advance a FIFO pointer; the index wraps at M_ISSUE-1 and flips the wrap bit
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p[IDX_W-1:0] == IDX_W'(M_ISSUE - 1)) begin
            r = {~p[PTR_W-1], {IDX_W{1'b0}}};
        end else begin
            r = {p[PTR_W-1], p[IDX_W-1:0] + IDX_W'(1)};
        end
        return r;
    endfunction

    // One-hot decode of a source index
    function automatic logic [S_COUNT-1:0] to_onehot(input logic [CL_S_COUNT-1:0] idx);
        logic [S_COUNT-1:0] oh;
        for (int i = 0; i < S_COUNT; i++) begin
            oh[i] = (idx == CL_S_COUNT'(i));
        end
        return oh;
    endfunction

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // Source index at a given search offset after the last granted source
    function automatic logic [CL_S_COUNT-1:0] rr_index(input logic [CL_S_COUNT-1:0] last,
                                                       input int offset);
        int sum;
        sum = int'(last) + 1 + offset;
        return CL_S_COUNT'(sum % S_COUNT);
    endfunction
`endif

    assign any_req_s = |s_req;
    assign push_s    = grant_valid_r && m_aready;
    assign pop_s     = m_resp_done && head_valid_r;
    // (outstanding - pop) < M_ISSUE; a pop implies outstanding >= 1
    assign admit_s   = (outstanding_r < CL_ISSUE'(M_ISSUE)) || pop_s;

    // Winner search: scanned from lowest to highest priority so the best match is written last
    always_comb begin
        winner_s = '0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_req[rr_index(last_r, i)]) begin
                winner_s = rr_index(last_r, i);
            end else begin
                winner_s = winner_s;
            end
        end
`else
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_req[i]) begin
                winner_s = CL_S_COUNT'(i);
            end else begin
                winner_s = winner_s;
            end
        end
`endif
        winner_onehot_s = to_onehot(winner_s);
    end

    // Grant FSM with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            s_grant_r       <= '0;
            grant_valid_r   <= 1'b0;
            grant_encoded_r <= '0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            last_r          <= CL_S_COUNT'(S_COUNT - 1);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s && admit_s) begin
                        state_r         <= GRANT;
                        s_grant_r       <= winner_onehot_s;
                        grant_valid_r   <= 1'b1;
                        grant_encoded_r <= winner_s;
                    end
                end
                GRANT: begin
                    // Grant is held without re-sampling s_req until the port accepts
                    if (m_aready) begin
                        state_r         <= IDLE;
                        s_grant_r       <= '0;
                        grant_valid_r   <= 1'b0;
                        grant_encoded_r <= '0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
                        last_r          <= grant_encoded_r;
`endif
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    s_grant_r       <= '0;
                    grant_valid_r   <= 1'b0;
                    grant_encoded_r <= '0;
                end
            endcase
        end
    end

    // Next-state values for the ordering FIFO and outstanding counter
    always_comb begin
        next_wr_s    = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        next_rd_s    = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        next_empty_s = (next_rd_s == next_wr_s);
        case ({push_s, pop_s})
            2'b10:   next_out_s = outstanding_r + CL_ISSUE'(1);
            2'b01:   next_out_s = outstanding_r - CL_ISSUE'(1);
            default: next_out_s = outstanding_r;
        endcase
        // Head after this cycle: the pushed entry if the FIFO was drained to it, else storage
        if (next_empty_s) begin
            next_head_s = head_r;
        end else if (push_s && (next_rd_s == wr_ptr_r)) begin
            next_head_s = grant_encoded_r;
        end else begin
            next_head_s = mem_r[next_rd_s[IDX_W-1:0]];
        end
    end

    // FIFO pointers, registered head, outstanding count and full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            head_r        <= '0;
            head_valid_r  <= 1'b0;
            outstanding_r <= '0;
            full_r        <= 1'b0;
        end else begin
            wr_ptr_r      <= next_wr_s;
            rd_ptr_r      <= next_rd_s;
            head_r        <= next_head_s;
            head_valid_r  <= ~next_empty_s;
            outstanding_r <= next_out_s;
            full_r        <= (next_out_s == CL_ISSUE'(M_ISSUE));
        end
    end

    // FIFO storage; contents behind the pointers are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= grant_encoded_r;
        end
    end

    assign s_grant           = s_grant_r;
    assign grant_valid       = grant_valid_r;
    assign grant_encoded     = grant_encoded_r;
    assign resp_select       = head_r;
    assign resp_select_valid = head_valid_r;
    assign outstanding       = outstanding_r;
    assign full              = full_r;

endmodule

// File: doc/axil_crossbar_m_arb.md
# axil_crossbar_m_arb

Per-master-port admission arbiter for the AXI-lite crossbar. It shares one master interface among S_COUNT slave-side address decoders, granting one requester at a time and capping outstanding transactions at M_ISSUE. Granted source indices go into an ordering FIFO so that returning B/R responses are routed back in issue order. One instance sits on each master interface, separately for the write path and the read path.

## Interface
- S_COUNT, 4, number of requesting slave interfaces (1..16)
- M_ISSUE, 4, maximum outstanding transactions on this master port (1..16); also the ordering FIFO depth
- CL_S_COUNT, S_COUNT>1 ? $clog2(S_COUNT) : 1, derived, do not override
- CL_ISSUE, $clog2(M_ISSUE+1), derived, do not override

- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_req  input  S_COUNT  per-source address request targeting this master; held until accepted
- s_grant  output  S_COUNT  one-hot grant, registered
- grant_valid  output  1  a grant is active
- grant_encoded  output  CL_S_COUNT  binary index of granted source
- m_aready  input  1  master port accepted the granted address this cycle
- m_resp_done  input  1  one response (B or R) completed its handshake this cycle
- resp_select  output  CL_S_COUNT  source index for the response at FIFO head
- resp_select_valid  output  1  ordering FIFO non-empty
- outstanding  output  CL_ISSUE  current outstanding count
- full  output  1  outstanding == M_ISSUE

## Operation
- FSM states:
  - IDLE: no grant held.
  - GRANT: grant held.
- IDLE → GRANT when |s_req is set and admission passes. Winner is loaded into s_grant and grant_encoded; grant_valid=1.
- Admission: (outstanding − pop) < M_ISSUE, where pop = m_resp_done && resp_select_valid in the same cycle.
- GRANT holds the grant unchanged until grant_valid && m_aready. It does not re-sample s_req; sources must not drop a request while granted.
- Accept cycle (GRANT with m_aready=1):
  - push grant_encoded into the ordering FIFO;
  - outstanding += 1;
  - record the winner as last-granted;
  - go to IDLE, grant cleared.
- Response: m_resp_done with FIFO non-empty pops the head and decrements outstanding. m_resp_done with FIFO empty is ignored; count stays 0.
- Simultaneous push and pop: FIFO advances both pointers, outstanding unchanged.
- FIFO pointers are CL_S_COUNT-agnostic, sized $clog2(M_ISSUE)+1 bits with a wrap bit. Full/empty are decided by the wrap-bit comparison.
- Reset mid-operation: grant dropped, FIFO flushed, count cleared. Any in-flight responses become don't-care.

## Timing
- Reset values:
  - s_grant=0, grant_valid=0, grant_encoded=0
  - resp_select=0, resp_select_valid=0
  - outstanding=0, full=0
  - last-granted=S_COUNT−1
  - state IDLE
- Request seen in cycle N (IDLE) → grant outputs valid in cycle N+1.
- Accept in cycle N → grant low in N+1; re-arbitration earliest in N+1; next grant in N+2. Peak throughput is one address per 2 cycles.
- Push in cycle N → resp_select_valid and outstanding update in N+1.
- full and outstanding are registered.
- resp_select is the FIFO head register, stable while resp_select_valid=1 and no pop.

## Configuration
- AXIL_ARB_ROUND_ROBIN_EN
  - Defined: round-robin. Search starts at last-granted+1 modulo S_COUNT; after reset source 0 has highest priority.
  - Undefined: fixed priority, lowest index wins, and the last-granted register is not implemented.

## Test plan
- Reset, then s_req=4'b0001 → s_grant=0001 one cycle later. Assert m_aready → outstanding=1, resp_select=0, resp_select_valid=1. Assert m_resp_done → outstanding=0.
- s_req=4'b1111 held, m_aready=1 whenever granted, with round-robin → grant order 0,1,2,3,0. Without the macro → 0,0,0,0.
- M_ISSUE=2, three accepted grants attempted with no responses → third grant withheld and full=1. One m_resp_done → grant issued the next cycle.
- Accept from source 2 and m_resp_done in the same cycle with outstanding=1 → outstanding stays 1. resp_select shows 2 once the older entry has been popped.
- Sources 3, 1, 0 accepted in that order → responses are routed with resp_select 3, 1, 0 in sequence.
- rst_n asserted low while in GRANT with outstanding=3 → all outputs return to reset values immediately, without waiting for a clock edge.
